// File: rtl/cpu_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_sequencer_pkg
//  Description : Shared machine-state encoding and sizing constants for the
//                CPU phase sequencer and its bus-wait watchdog.
//  Revision    : 1.0  initial release
// ============================================================================
package cpu_sequencer_pkg;

  // Machine-state codes. Code 7 is deliberately unused; the sequencer
  // recovers from it to IDLE.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_IF1  = 3'd1,
    ST_IF2  = 3'd2,
    ST_EX1  = 3'd3,
    ST_EX2  = 3'd4,
    ST_EX3  = 3'd5,
    ST_EX4  = 3'd6
  } state_e;

  // Wait counter width: large enough for the full 1..65535 timeout range.
  localparam int unsigned WAIT_W = 16;

  // States in which the bus may stall and the watchdog is armed.
  function automatic logic is_wait_state(input state_e s);
    return (s == ST_IF2) || (s == ST_EX2);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_sequencer_wait_watchdog.sv
`default_nettype none
// ============================================================================
//  Module      : wait_watchdog
//  Description : Counts cycles spent waiting on the bus and raises a
//                combinational expire strobe on the cycle the count would
//                reach TIMEOUT_CYCLES without a done.
//  Ports       : clk, rst      clock / synchronous active-high reset
//                clear         restart the count (state change)
//                waiting       current state is a watched wait state
//                done          phase complete this cycle (beats expire)
//                expire        abort request, one cycle
//  Revision    : 1.0  initial release
// ============================================================================
module wait_watchdog
  import cpu_sequencer_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic waiting,
  input  logic done,
  output logic expire
);

  localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(TIMEOUT_CYCLES - 1);

  logic [WAIT_W-1:0] cnt_q;
  logic [WAIT_W-1:0] cnt_d;

  // cnt_q holds the stalled cycles already completed; this cycle is the
  // TIMEOUT_CYCLES-th one when cnt_q == LIMIT. A done in that cycle wins.
  assign expire = waiting && !done && (cnt_q == LIMIT);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (waiting && !done) begin
      cnt_d = cnt_q + WAIT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/cpu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_sequencer
//  Description : Multi-cycle phase generator. Owns the machine-state register
//                (IDLE, IF1, IF2, EX1..EX4), emits fetch/execute strobes and
//                entry pulses for the control decoder, advances on
//                output_done, aborts stalled bus phases and counts retired
//                instructions.
//  Ports       : clk, rst             clock / synchronous active-high reset
//                run                  allow fetching (sampled at boundaries)
//                output_done          phase complete from control decoder
//                ins_*                one-hot decode flags
//                Mif, Mex             fetch / execute cycle
//                T1_Mif, T2_Mif       entry pulses for IF1 / IF2
//                T1..T4               entry pulses for EX1..EX4
//                cur_state            state code
//                busy                 not IDLE
//                retire               instruction completed (registered)
//                instr_count          retired instruction count (wraps)
//                bus_timeout          watchdog abort pulse (registered)
//  Revision    : 1.0  initial release
// ============================================================================
module cpu_sequencer
  import cpu_sequencer_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             output_done,
  input  logic             ins_ADD,
  input  logic             ins_SUB,
  input  logic             ins_SW,
  input  logic             ins_LW,
  input  logic             ins_ADDI,
  input  logic             ins_LUI,
  input  logic             ins_JAL,
  output logic             Mif,
  output logic             Mex,
  output logic             T1_Mif,
  output logic             T2_Mif,
  output logic             T1,
  output logic             T2,
  output logic             T3,
  output logic             T4,
  output logic [2:0]       cur_state,
  output logic             busy,
  output logic             retire,
  output logic [CNT_W-1:0] instr_count,
  output logic             bus_timeout
);

  // Number of execute phases for the decoded instruction. Anything not
  // multi-phase (ALU ops, JAL, LUI, no flag, or an illegal multi-hot
  // pattern) takes a single phase.
  function automatic logic [2:0] phase_count(input logic [6:0] flags);
    case (flags)
      7'b000_1000: phase_count = 3'd3;  // LW
      7'b000_0100: phase_count = 3'd2;  // SW
      default:     phase_count = 3'd1;
    endcase
  endfunction

  state_e           state_q, state_d;
  logic             entry_q, entry_d;
  logic             retire_q, retire_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic       w_expire;
  logic       w_final;
  logic       w_clear;
  logic [2:0] w_phase_n;
  logic [2:0] w_ex_idx;

  assign w_phase_n = phase_count({ins_JAL, ins_LUI, ins_ADDI, ins_LW,
                                  ins_SW, ins_SUB, ins_ADD});
  // Execute phase index: EX1 -> 1 ... EX4 -> 4.
  assign w_ex_idx  = 3'(state_q) - 3'd2;
  assign w_clear   = (state_d != state_q);

  wait_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wait_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (w_clear),
    .waiting(is_wait_state(state_q)),
    .done   (output_done),
    .expire (w_expire)
  );

  // Next-state logic. output_done is checked before the watchdog so a done
  // arriving on the timeout cycle still advances.
  always_comb begin
    state_d = state_q;
    w_final = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (run) state_d = ST_IF1;
      end
      ST_IF1: begin
        state_d = ST_IF2;
      end
      ST_IF2: begin
        if (output_done)   state_d = ST_EX1;
        else if (w_expire) state_d = ST_IDLE;
      end
      ST_EX1, ST_EX2, ST_EX3, ST_EX4: begin
        if (output_done) begin
          if (w_ex_idx < w_phase_n) begin
            state_d = state_e'(3'(state_q) + 3'd1);
          end else begin
            // Instruction boundary: the only place run is honoured
            // outside IDLE.
            w_final = 1'b1;
            state_d = run ? ST_IF1 : ST_IDLE;
          end
        end else if (w_expire) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    entry_d   = (state_d != state_q);
    retire_d  = w_final;
    timeout_d = w_expire;
    count_d   = count_q + (w_final ? CNT_W'(1) : CNT_W'(0));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      entry_q   <= 1'b0;
      retire_q  <= 1'b0;
      timeout_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      entry_q   <= entry_d;
      retire_q  <= retire_d;
      timeout_q <= timeout_d;
      count_q   <= count_d;
    end
  end

  // Moore decode: registered state plus the registered entry flag, so each
  // T pulse lasts exactly the first cycle of its state.
  assign cur_state   = 3'(state_q);
  assign busy        = (state_q != ST_IDLE);
  assign Mif         = (state_q == ST_IF1) || (state_q == ST_IF2);
  assign Mex         = (state_q == ST_EX1) || (state_q == ST_EX2) ||
                       (state_q == ST_EX3) || (state_q == ST_EX4);
  assign T1_Mif      = entry_q && (state_q == ST_IF1);
  assign T2_Mif      = entry_q && (state_q == ST_IF2);
  assign T1          = entry_q && (state_q == ST_EX1);
  assign T2          = entry_q && (state_q == ST_EX2);
  assign T3          = entry_q && (state_q == ST_EX3);
  assign T4          = entry_q && (state_q == ST_EX4);
  assign retire      = retire_q;
  assign bus_timeout = timeout_q;
  assign instr_count = count_q;

endmodule
`default_nettype wire
